// File: rtl/clic_irq_sched.sv
// CLIC interrupt scheduler: per-source gateway, registered priority arbiter and
// valid/ready/kill handshake sequencer toward the core.
module clic_irq_sched #(
  parameter int N_SOURCE   = 32,
  parameter int INTCTLBITS = 8,
  localparam int ID_W      = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SOURCE-1:0]      src_i,
  input  logic [N_SOURCE-1:0][7:0] intctl_i,
  input  logic [N_SOURCE-1:0]      ie_i,
  input  logic [N_SOURCE-1:0]      le_i,
  input  logic [N_SOURCE-1:0]      shv_i,
  input  logic [N_SOURCE-1:0]      ip_sw_i,
  input  logic [7:0]               thresh_i,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic                     irq_valid_o,
  input  logic                     irq_ready_i,
  output logic [ID_W-1:0]          irq_id_o,
  output logic [7:0]               irq_level_o,
  output logic                     irq_shv_o,
  output logic                     irq_kill_req_o,
  input  logic                     irq_kill_ack_i
);

  localparam int LOW_BITS = 8 - INTCTLBITS;
  localparam logic [7:0] LOW_MASK = 8'((1 << LOW_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    KILL   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  // Unimplemented intctl LSBs arbitrate as ones.
  function automatic logic [7:0] eff_lvl(input logic [7:0] ctl);
    return ctl | LOW_MASK;
  endfunction

  logic [N_SOURCE-1:0] src_p0;
  logic [N_SOURCE-1:0] ip_p0;
  logic [N_SOURCE-1:0] ip_d;

  logic                vld_p1;
  logic [ID_W-1:0]     win_id_p1;
  logic [7:0]          win_lvl_p1;
  logic                win_shv_p1;

  logic                best_vld;
  logic [ID_W-1:0]     best_id;
  logic [7:0]          best_lvl;
  logic                best_shv;

  state_t              state_q, state_d;
  logic                vld_p2, vld_d;
  logic                kill_p2, kill_d;
  logic [ID_W-1:0]     id_p2, id_d;
  logic [7:0]          lvl_p2, lvl_d;
  logic                shv_p2, shv_d;
  logic                claim;

  // ---- stage p0: gateway (edge detect / level follow, claim clear) ----
  always_comb begin
    ip_d = ip_p0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (le_i[i]) begin
        // A new edge or software set wins over a claim in the same cycle.
        ip_d[i] = (src_i[i] & ~src_p0[i]) | (ip_sw_i[i] & ~ip_p0[i]) |
                  (ip_p0[i] & ~(claim && (id_p2 == ID_W'(i))));
      end else begin
        ip_d[i] = src_i[i] | ip_sw_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_p0 <= '0;
      ip_p0  <= '0;
    end else begin
      src_p0 <= src_i;
      ip_p0  <= ip_d;
    end
  end

  assign ip_o = ip_p0;

  // ---- stage p1: arbitration max, ties resolved toward the higher ID ----
  always_comb begin
    best_vld = 1'b0;
    best_id  = '0;
    best_lvl = '0;
    best_shv = 1'b0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (ip_p0[i] && ie_i[i] && (eff_lvl(intctl_i[i]) > thresh_i) &&
          (!best_vld || (eff_lvl(intctl_i[i]) >= best_lvl))) begin
        best_vld = 1'b1;
        best_id  = ID_W'(i);
        best_lvl = eff_lvl(intctl_i[i]);
        best_shv = shv_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      win_id_p1  <= '0;
      win_lvl_p1 <= '0;
      win_shv_p1 <= 1'b0;
    end else begin
      vld_p1     <= best_vld;
      win_id_p1  <= best_id;
      win_lvl_p1 <= best_lvl;
      win_shv_p1 <= best_shv;
    end
  end

  // ---- stage p2: handshake sequencer and presented interrupt ----
  always_comb begin
    state_d = state_q;
    vld_d   = vld_p2;
    kill_d  = kill_p2;
    id_d    = id_p2;
    lvl_d   = lvl_p2;
    shv_d   = shv_p2;
    claim   = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld_p1) begin
          vld_d   = 1'b1;
          id_d    = win_id_p1;
          lvl_d   = win_lvl_p1;
          shv_d   = win_shv_p1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (irq_ready_i) begin
          claim   = 1'b1;
          vld_d   = 1'b0;
          state_d = WAIT;
        end else if ((vld_p1 && (win_lvl_p1 > lvl_p2)) ||
                     !(ip_p0[id_p2] && ie_i[id_p2])) begin
          kill_d  = 1'b1;
          state_d = KILL;
        end
      end
      KILL: begin
        if (irq_ready_i) begin
          claim   = 1'b1;
          vld_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = WAIT;
        end else if (irq_kill_ack_i) begin
          vld_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = WAIT;
        end
      end
      // One settling cycle lets the winner stage see the post-claim pending state.
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vld_p2  <= 1'b0;
      kill_p2 <= 1'b0;
      id_p2   <= '0;
      lvl_p2  <= '0;
      shv_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p2  <= vld_d;
      kill_p2 <= kill_d;
      id_p2   <= id_d;
      lvl_p2  <= lvl_d;
      shv_p2  <= shv_d;
    end
  end

  assign irq_valid_o    = vld_p2;
  assign irq_kill_req_o = kill_p2;
  assign irq_id_o       = id_p2;
  assign irq_level_o    = lvl_p2;
  assign irq_shv_o      = shv_p2;

endmodule

// File: doc/clic_irq_sched.md
Name: clic_irq_sched

Overview:
- Per-source interrupt gateway plus priority arbiter and core handshake sequencer for the CLIC.
- Consumes the per-source configuration fields from the CLIC register file (ctl, ie, attr_trig edge bit, shv, software-written ip).
- Produces the hardware pending vector written back into the register file each cycle.
- Selects the highest-level pending, enabled interrupt and presents it to the core with a valid/ready handshake, including kill (preemption/withdrawal) sequencing.

Parameters:
- N_SOURCE, 32, number of interrupt sources.
- INTCTLBITS, 8, number of implemented MSBs of each intctl; the remaining LSBs read as 1 for arbitration.
- ID_W, $clog2(N_SOURCE), interrupt ID width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- src_i  in  N_SOURCE  raw interrupt lines, synchronous to clk_i.
- intctl_i  in  8 x N_SOURCE  per-source level/priority.
- ie_i  in  N_SOURCE  per-source enable.
- le_i  in  N_SOURCE  1 = edge-triggered, 0 = level-triggered.
- shv_i  in  N_SOURCE  selective hardware vectoring.
- ip_sw_i  in  N_SOURCE  software pending bit from the register file.
- thresh_i  in  8  interrupt threshold.
- ip_o  out  N_SOURCE  gateway pending state, written to the register file every cycle.
- irq_valid_o  out  1  interrupt presented to the core.
- irq_ready_i  in  1  core accepts the presented interrupt.
- irq_id_o  out  ID_W  presented source ID.
- irq_level_o  out  8  presented effective level.
- irq_shv_o  out  1  presented shv bit.
- irq_kill_req_o  out  1  request to withdraw the presented interrupt.
- irq_kill_ack_i  in  1  core confirms the withdrawal.

Behaviour:
- Reset: ip_q=0, src_q=0, winner regs=0, state=IDLE. All outputs 0.
- Gateway, edge mode (le_i=1):
  - ip_q[i] sets on src_i & ~src_q, or on ip_sw_i & ~ip_o[i] (software set).
  - ip_q[i] clears on claim of ID i.
  - Set wins over a simultaneous clear.
- Gateway, level mode (le_i=0): ip_q[i] <= src_i[i] | ip_sw_i[i]. Claim has no effect.
- ip_o = ip_q.
- Effective level: eff[i] = intctl_i[i] with the low (8-INTCTLBITS) bits forced to 1.
- Candidate: cand[i] = ip_q[i] & ie_i[i] & (eff[i] > thresh_i).
- Arbitration: a combinational max over the candidates, registered into winner_valid_q, winner_id_q, winner_lvl_q and winner_shv_q every cycle.
  - Highest eff wins; on ties, the highest ID wins.
  - No candidate -> winner_valid_q = 0.
- Latency: src_i rising sampled at edge k -> ip_q=1 after k -> winner_q after k+1 -> irq_valid_o=1 after k+2 (3 cycles).
- FSM states: IDLE, ACTIVE, KILL, WAIT.
- IDLE:
  - If winner_valid_q: latch id/lvl/shv into the output regs, set irq_valid_o=1, go to ACTIVE.
- ACTIVE (outputs held stable while irq_valid_o=1):
  - If irq_ready_i: claim the ID (clear ip_q[id] if le_i[id]=1), irq_valid_o=0, go to WAIT.
  - Else if winner_valid_q & (winner_lvl_q > irq_level_o), or if ~(ip_q[id] & ie_i[id]): irq_kill_req_o=1, go to KILL.
  - irq_ready_i has priority over a simultaneous kill condition.
- KILL:
  - irq_valid_o and irq_kill_req_o both stay 1.
  - If irq_ready_i: claim as in ACTIVE, drop both outputs, go to WAIT. Ready wins if kill_ack arrives in the same cycle.
  - Else if irq_kill_ack_i: drop both outputs (no claim), go to WAIT.
- WAIT: one cycle, so that winner_q reflects the post-claim ip_q; then go to IDLE. This prevents re-presenting a stale, already-claimed source.
- Threshold and config changes take effect through the winner pipeline only; presented outputs never change while irq_valid_o=1.
- Reset asserted mid-handshake: everything returns to reset values asynchronously, and pending edges are lost.

Test Plan:
1. Edge source 3 (intctl=0x80, ie=1, le=1, thresh=0): pulse src_i[3] for 1 cycle -> irq_valid_o=1 three cycles later, id=3, level=0x80. Assert ready -> ip_o[3]=0 the next cycle; valid stays 0 for WAIT+IDLE.
2. Sources 2 and 5 pending, both intctl=0x40 -> id=5. Then set source 2 to intctl=0x41 and re-pend -> id=2.
3. Source 1 presented at level 0x20 and not ready; source 7 goes pending at 0x90 -> irq_kill_req_o=1 with valid held. Assert kill_ack -> valid=0; after WAIT, id=7 is presented, and source 1 is still pending (ip_o[1]=1).
4. Level source 4 presented; deassert src_i[4] -> kill_req. Simultaneously assert ready and kill_ack -> treated as a claim, no re-presentation.
5. thresh_i=0x80 with sole source at intctl=0x80 -> never valid. Set thresh_i=0x7F -> valid after 2 cycles.
6. INTCTLBITS=3, intctl=0xA0 -> irq_level_o=0xBF. Assert rst_ni low during KILL -> all outputs 0 immediately, ip_o=0.
